hub75_scan_ctrl: RTL

HUB75_SCAN_CTRL -- requirements
Module: hub75_scan_ctrl

---
 rtl/hub75_scan_ctrl.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/hub75_scan_ctrl.sv
// HUB75 LED panel scanner: shifts one row-pair bit plane out of a sync-read framebuffer,
// latches it, then lights it for a binary-weighted (BCM) display time.
module hub75_scan_ctrl #(
    parameter int COLS          = 64,
    parameter int ROW_ADDR_BITS = 4,
    parameter int BCM_BITS      = 4,
    parameter int BASE_TICKS    = 8
) (
    input  logic                                   clk,
    input  logic                                   reset,
    input  logic                                   enable,
    output logic [ROW_ADDR_BITS+$clog2(COLS)-1:0]  fb_addr,
    input  logic [6*BCM_BITS-1:0]                  fb_data,
    output logic [5:0]                             hub_rgb,
    output logic                                   hub_clk,
    output logic                                   hub_lat,
    output logic                                   hub_oe_n,
    output logic [ROW_ADDR_BITS-1:0]               hub_row,
    output logic                                   frame_done
);

    localparam int COL_BITS  = $clog2(COLS);
    localparam int CW        = COL_BITS + 1;
    localparam int PW        = (BCM_BITS > 1) ? $clog2(BCM_BITS) : 1;
    localparam int MAX_TICKS = BASE_TICKS << (BCM_BITS - 1);
    localparam int TW        = $clog2(MAX_TICKS + 1);

    typedef enum logic [1:0] {IDLE, SHIFT, LATCH, DISPLAY} state_t;

    state_t                   state, state_n;
    logic [ROW_ADDR_BITS-1:0] row, row_n;
    logic [PW-1:0]            plane, plane_n;
    logic [CW-1:0]            col, col_n;
    logic                     phase, phase_n;
    logic [TW-1:0]            tick, tick_n, dur_m1;
    logic                     last_tick, last_plane, last_row;

    always_comb begin
        dur_m1     = (TW'(BASE_TICKS) << plane) - TW'(1);
        last_tick  = (tick == dur_m1);
        last_plane = (plane == PW'(BCM_BITS - 1));
        last_row   = (row == '1);

        state_n = state;
        row_n   = row;
        plane_n = plane;
        col_n   = col;
        phase_n = phase;
        tick_n  = tick;

        case (state)
            IDLE: begin
                if (enable) begin
                    state_n = SHIFT;
                    row_n   = '0;
                    plane_n = '0;
                    col_n   = '0;
                    phase_n = 1'b0;
                end
            end
            SHIFT: begin
                if (!phase) begin
                    phase_n = 1'b1;
                end else begin
                    phase_n = 1'b0;
                    if (col == CW'(COLS)) begin
                        state_n = LATCH;
                    end else begin
                        col_n = col + CW'(1);
                    end
                end
            end
            LATCH: begin
                state_n = DISPLAY;
                tick_n  = '0;
            end
            DISPLAY: begin
                if (!last_tick) begin
                    tick_n = tick + TW'(1);
                end else begin
                    tick_n  = '0;
                    col_n   = '0;
                    phase_n = 1'b0;
                    if (last_plane) begin
                        plane_n = '0;
                        row_n   = row + ROW_ADDR_BITS'(1);
                    end else begin
                        plane_n = plane + PW'(1);
                    end
                    if (enable) begin
                        state_n = SHIFT;
                    end else begin
                        state_n = IDLE;
                        row_n   = '0;
                        plane_n = '0;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    // Outputs are registered from next-state values so they line up with the state they describe.
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            row        <= '0;
            plane      <= '0;
            col        <= '0;
            phase      <= 1'b0;
            tick       <= '0;
            fb_addr    <= '0;
            hub_rgb    <= '0;
            hub_clk    <= 1'b0;
            hub_lat    <= 1'b0;
            hub_oe_n   <= 1'b1;
            hub_row    <= '0;
            frame_done <= 1'b0;
        end else begin
            state <= state_n;
            row   <= row_n;
            plane <= plane_n;
            col   <= col_n;
            phase <= phase_n;
            tick  <= tick_n;

            if (state_n == SHIFT && !phase_n && col_n < CW'(COLS)) begin
                fb_addr <= {row_n, col_n[COL_BITS-1:0]};
            end

            // RAM data for the address shown in phase 0 arrives during phase 1 of the same slot.
            if (state == SHIFT && phase && col < CW'(COLS)) begin
                for (int unsigned c = 0; c < 6; c++) begin
                    hub_rgb[c] <= fb_data[c*BCM_BITS + plane];
                end
            end

            hub_clk  <= (state_n == SHIFT) && phase_n && (col_n != '0);
            hub_lat  <= (state_n == LATCH);
            hub_oe_n <= (state_n != DISPLAY);

            if (state_n == LATCH) begin
                hub_row <= row_n;
            end

            frame_done <= (state_n == DISPLAY) && (tick_n == dur_m1) && last_plane && last_row;
        end
    end

endmodule
